// File: rtl/timer_irq_pkg.sv
// Shared CPU address map for the timer peripheral and its TCON bit layout.
// Also used by the data-memory decoder, so both sides agree on the word-aligned compare.
package timer_irq_pkg;

    localparam logic [31:0] TIMER_BASE_ADDR = 32'h4000_0000;
    localparam logic [31:0] TH_OFFSET       = 32'h0000_0000;
    localparam logic [31:0] TL_OFFSET       = 32'h0000_0004;
    localparam logic [31:0] TCON_OFFSET     = 32'h0000_0008;

    localparam int TCON_WIDTH  = 3;
    localparam int TCON_EN_BIT = 0;
    localparam int TCON_IE_BIT = 1;
    localparam int TCON_ST_BIT = 2;

    // Word-granular match: the two byte-lane bits of the bus address are ignored.
    function automatic logic word_match(input logic [31:0] addr, input logic [31:0] target);
        return (addr >> 2) == (target >> 2);
    endfunction

endpackage

// File: rtl/timer_counter.sv
// TL counter with TH reload; single-cycle update, bus writes always accepted (no backpressure).
// A bus write to TL takes priority over a reload or an increment on the same edge.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        th_wr,
    input  logic        tl_wr,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic        reload
);

    assign reload = en && (tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            th <= '0;
            tl <= '0;
        end else begin
            if (th_wr) begin
                th <= wdata;
            end
            // Reload uses the TH value held before this edge, so a TH write
            // only affects the following reload.
            if (tl_wr) begin
                tl <= wdata;
            end else if (reload) begin
                tl <= th;
            end else if (en) begin
                tl <= tl + 32'd1;
            end
        end
    end

endmodule

// File: rtl/timer_irq.sv
// Memory-mapped timer with interrupt: writes land in one cycle, reads and IRQ are combinational.
// No backpressure: every bus access completes in the cycle it is presented.
module timer_irq
    import timer_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWr,
    input  logic        MemRd,
    input  logic        PC_super,
    output logic [31:0] ReadData,
    output logic        IRQ,
    output logic [2:0]  TCON_out
);

    logic                  sel_th;
    logic                  sel_tl;
    logic                  sel_tcon;
    logic                  reload;
    logic [31:0]           th;
    logic [31:0]           tl;
    logic [TCON_WIDTH-1:0] tcon;

    assign sel_th   = word_match(Addr, BASE_ADDR + TH_OFFSET);
    assign sel_tl   = word_match(Addr, BASE_ADDR + TL_OFFSET);
    assign sel_tcon = word_match(Addr, BASE_ADDR + TCON_OFFSET);

    timer_counter u_counter (
        .clk    (clk),
        .reset  (reset),
        .en     (tcon[TCON_EN_BIT]),
        .th_wr  (MemWr && sel_th),
        .tl_wr  (MemWr && sel_tl),
        .wdata  (WriteData),
        .th     (th),
        .tl     (tl),
        .reload (reload)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tcon <= '0;
        end else if (MemWr && sel_tcon) begin
            tcon[TCON_EN_BIT] <= WriteData[TCON_EN_BIT];
            tcon[TCON_IE_BIT] <= WriteData[TCON_IE_BIT];
            // A reload coinciding with a status clear must not drop the interrupt.
            tcon[TCON_ST_BIT] <= WriteData[TCON_ST_BIT]
                               | (WriteData[TCON_IE_BIT] & reload);
        end else if (reload && tcon[TCON_IE_BIT]) begin
            tcon[TCON_ST_BIT] <= 1'b1;
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRd) begin
            if (sel_th) begin
                ReadData = th;
            end else if (sel_tl) begin
                ReadData = tl;
            end else if (sel_tcon) begin
                ReadData = {{(32-TCON_WIDTH){1'b0}}, tcon};
            end
        end
    end

    assign IRQ      = tcon[TCON_IE_BIT] & tcon[TCON_ST_BIT] & ~PC_super;
    assign TCON_out = tcon;

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: inputs change on the falling edge, outputs sampled mid-low-phase.
module tb_timer_irq;

    localparam logic [31:0] B = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemWr;
    logic        MemRd;
    logic        PC_super;
    logic [31:0] ReadData;
    logic        IRQ;
    logic [2:0]  TCON_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #20 clk = ~clk;

    timer_irq #(.BASE_ADDR(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemWr     (MemWr),
        .MemRd     (MemRd),
        .PC_super  (PC_super),
        .ReadData  (ReadData),
        .IRQ       (IRQ),
        .TCON_out  (TCON_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        Addr  = B + off;
        MemRd = 1'b1;
        #1;
        d     = ReadData;
        MemRd = 1'b0;
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] d;
        rd(off, d);
        check(tag, d, exp);
    endtask

    // Called just after a falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        Addr      = B + off;
        WriteData = d;
        MemWr     = 1'b1;
        @(negedge clk);
        MemWr     = 1'b0;
        Addr      = '0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset     = 1'b1;
        MemWr     = 1'b1;
        MemRd     = 1'b0;
        PC_super  = 1'b0;
        Addr      = B + 32'h4;
        WriteData = 32'h0000_DEAD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        MemWr = 1'b0;
        #1;

        check("rst_irq", {31'b0, IRQ}, 32'h0);
        check("rst_tcon_out", {29'b0, TCON_out}, 32'h0);
        Addr = B + 32'h4;
        #1;
        check("rst_rd_idle", ReadData, 32'h0);
        chk_rd("rst_tl", 32'h4, 32'h0);
        chk_rd("rst_th", 32'h0, 32'h0);
        chk_rd("rst_tcon", 32'h8, 32'h0);

        wr(32'h0, 32'hFFFF_FFFC);
        wr(32'h4, 32'hFFFF_FFFE);
        wr(32'h8, 32'h3);
        chk_rd("start_tl", 32'h4, 32'hFFFF_FFFE);
        check("start_tcon", {29'b0, TCON_out}, 32'h3);
        @(negedge clk); #1;
        chk_rd("inc_tl", 32'h4, 32'hFFFF_FFFF);
        check("pre_reload_irq", {31'b0, IRQ}, 32'h0);
        @(negedge clk); #1;
        chk_rd("reload_tl", 32'h4, 32'hFFFF_FFFC);
        check("reload_tcon", {29'b0, TCON_out}, 32'h7);
        check("reload_irq", {31'b0, IRQ}, 32'h1);

        PC_super = 1'b1; #1;
        check("irq_kernel_masked", {31'b0, IRQ}, 32'h0);
        PC_super = 1'b0; #1;
        check("irq_user_pending", {31'b0, IRQ}, 32'h1);
        wr(32'h8, 32'h1);
        check("irq_cleared", {31'b0, IRQ}, 32'h0);
        check("clr_tcon", {29'b0, TCON_out}, 32'h1);
        chk_rd("clr_tl", 32'h4, 32'hFFFF_FFFD);

        @(negedge clk);
        @(negedge clk); #1;
        chk_rd("pre_tcon_race_tl", 32'h4, 32'hFFFF_FFFF);
        wr(32'h8, 32'h3);
        check("tcon_race", {29'b0, TCON_out}, 32'h7);
        chk_rd("tcon_race_rd", 32'h8, 32'h7);
        chk_rd("tcon_race_tl", 32'h4, 32'hFFFF_FFFC);
        wr(32'h8, 32'h3);
        check("status_wr_clear", {29'b0, TCON_out}, 32'h3);
        check("status_wr_clear_irq", {31'b0, IRQ}, 32'h0);

        @(negedge clk);
        @(negedge clk); #1;
        chk_rd("pre_tl_race_tl", 32'h4, 32'hFFFF_FFFF);
        wr(32'h4, 32'h0000_1234);
        chk_rd("tl_race", 32'h4, 32'h0000_1234);
        check("tl_race_status", {29'b0, TCON_out}, 32'h7);
        @(negedge clk); #1;
        chk_rd("tl_race_next", 32'h4, 32'h0000_1235);

        chk_rd("rd_tcon_off9", 32'h9, 32'h7);
        chk_rd("rd_unmapped_off12", 32'hC, 32'h0);
        chk_rd("rd_th_off1", 32'h1, 32'hFFFF_FFFC);
        Addr = B + 32'h8; MemRd = 1'b0; #1;
        check("rd_no_strobe", ReadData, 32'h0);

        wr(32'h0, 32'h0000_0100);
        chk_rd("th_wr_tl_unchanged", 32'h4, 32'h0000_1236);
        chk_rd("th_wr_value", 32'h0, 32'h0000_0100);

        wr(32'h0, 32'hFFFF_FFFF);
        wr(32'h8, 32'h0);
        chk_rd("stop_tl", 32'h4, 32'h0000_1238);
        wr(32'h4, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        chk_rd("hold_tl", 32'h4, 32'hFFFF_FFFF);
        check("hold_tcon", {29'b0, TCON_out}, 32'h0);

        wr(32'h8, 32'h3);
        check("thmax_start_tcon", {29'b0, TCON_out}, 32'h3);
        @(negedge clk); #1;
        chk_rd("thmax_tl", 32'h4, 32'hFFFF_FFFF);
        check("thmax_status", {29'b0, TCON_out}, 32'h7);
        wr(32'h8, 32'h3);
        check("thmax_clear_lost", {29'b0, TCON_out}, 32'h7);
        wr(32'h8, 32'h1);
        check("ie_off_clear", {29'b0, TCON_out}, 32'h1);
        @(negedge clk); #1;
        check("ie_off_no_status", {29'b0, TCON_out}, 32'h1);

        wr(32'h8, 32'h6);
        check("sw_status_irq", {31'b0, IRQ}, 32'h1);
        @(negedge clk); #1;
        check("disabled_status_hold", {29'b0, TCON_out}, 32'h6);
        chk_rd("disabled_tl_hold", 32'h4, 32'hFFFF_FFFF);
        wr(32'h8, 32'h7);
        check("pending_before_reset", {31'b0, IRQ}, 32'h1);

        reset     = 1'b1;
        MemWr     = 1'b1;
        Addr      = B + 32'h8;
        WriteData = 32'h7;
        @(negedge clk);
        reset = 1'b0;
        MemWr = 1'b0;
        #1;
        check("midrst_tcon", {29'b0, TCON_out}, 32'h0);
        check("midrst_irq", {31'b0, IRQ}, 32'h0);
        chk_rd("midrst_tl", 32'h4, 32'h0);
        chk_rd("midrst_th", 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("post_rst_irq", {31'b0, IRQ}, 32'h0);
        chk_rd("post_rst_tl", 32'h4, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_irq.md
TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 Parameter BASE_ADDR, default 32'h4000_0000, byte address of TH; TL at +4, TCON at +8.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Addr  input  32  data-bus byte address from the ALU result.
REQ-005 WriteData  input  32  data-bus write value.
REQ-006 MemWr  input  1  bus write strobe, from the Control unit.
REQ-007 MemRd  input  1  bus read strobe, from the Control unit.
REQ-008 PC_super  input  1  PC[31] of the current instruction; 1 = kernel mode.
REQ-009 ReadData  output  32  register read value; combinational from Addr and MemRd.
REQ-010 IRQ  output  1  interrupt request to the Control unit, which selects the exception PCSrc.
REQ-011 TCON_out  output  3  debug view of TCON[2:0].

Function
REQ-012 Registers SHALL be TH[31:0] (reload value), TL[31:0] (counter) and TCON[2:0]: bit0 = count enable, bit1 = interrupt enable, bit2 = interrupt status.
REQ-013 Address decode SHALL match Addr[31:2] only; Addr[1:0] SHALL be ignored.
REQ-014 A write SHALL take effect on the clock edge when MemWr=1 and Addr matches; only TCON bits [2:0] are written, and the upper bits read as 0.
REQ-015 ReadData SHALL return the register at the matched address when MemRd=1, and 32'h0 otherwise or when unmatched.
REQ-016 With TCON[0]=1 and no TL write, TL SHALL increment by 1 each cycle.
REQ-017 When TL=32'hFFFF_FFFF and TCON[0]=1, the next TL SHALL be TH (reload), not 0.
REQ-018 On that reload edge, if TCON[1]=1, TCON[2] SHALL be set to 1.
REQ-019 With TCON[0]=0, TL and TCON[2] SHALL hold.
REQ-020 IRQ SHALL be combinational: TCON[1] & TCON[2] & ~PC_super.
REQ-021 IRQ SHALL stay asserted until software clears TCON[2] or TCON[1]; there SHALL be no auto-clear.
REQ-022 If a TL write and a reload fall on the same edge, the bus write to TL SHALL win.
REQ-023 If a TCON write and a reload fall on the same edge, TCON[1:0] SHALL take WriteData and TCON[2] SHALL be WriteData[2] | (WriteData[1] & reload); an interrupt SHALL never be lost to a simultaneous clear.
REQ-024 A write to TH SHALL NOT alter TL; the new TH is used from the next reload.
REQ-025 With TH=32'hFFFF_FFFF, a reload SHALL occur every cycle and status SHALL set on each reload.

Reset
REQ-026 While reset=1 at an edge, TH, TL and TCON SHALL be cleared to 0.
REQ-027 After reset, IRQ SHALL be 0 and ReadData SHALL be 0 when MemRd=0.
REQ-028 Reset SHALL override simultaneous bus writes and counting.
REQ-029 Reset asserted mid-count SHALL discard any pending status; no IRQ SHALL follow deassertion.

Structure
REQ-030 A shared CPU package SHALL hold the peripheral base address, the TH/TL/TCON offsets and the TCON bit-index constants; the data-memory address decoder SHALL also use these.
REQ-031 One sub-module, timer_counter, SHALL hold TL, TH and the reload/increment logic; the top SHALL hold decode, TCON and IRQ.
REQ-032 No other clocks or latches SHALL be used; all flops SHALL be on clk.

Verification
REQ-033 Reset held 2 cycles with MemWr=1 to TL -> TL=0, TCON=0, IRQ=0 after release.
REQ-034 Write TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFE, TCON=3'b011 -> TL=FFFF_FFFF after 1 cycle, then TL=FFFF_FFFC and TCON[2]=1; IRQ=1 with PC_super=0.
REQ-035 Pending IRQ, PC_super=1 -> IRQ=0; PC_super=0 -> IRQ=1; write TCON=3'b001 -> IRQ=0 next cycle.
REQ-036 Write TCON=3'b011 on the same edge as a reload -> TCON reads 3'b111 after the edge.
REQ-037 Write TL=32'h1234 on the same edge as a reload -> TL=32'h1234, then 32'h1235.
REQ-038 MemRd=1, Addr=BASE_ADDR+9 -> ReadData=TCON zero-extended; Addr=BASE_ADDR+12 -> ReadData=0.
